tensor_core_matmul_sequencer: RTL and testbench

- Sequences one shared signed MAC unit to compute the 3x3 product C = A x B.
- A is tensor register file matrix 0; B is matrix 1.
- Controller sits between the CPU's TENSOR_CORE_OPERATE decode and the tensor core register file.
- Reads operands through the file's combinational read ports, buffers all nine results internally, then writes them back in place over matrix 0.

---
 rtl/tensor_core_matmul_sequencer.sv | 169 ++++++++++++++++
 tb/tb_tensor_core_matmul_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tensor_core_matmul_sequencer.sv
// Drives one shared signed MAC through a 3x3 matrix product C = A x B.
// The nine saturated results are buffered and then written back over matrix 0.
module tensor_core_matmul_sequencer #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DIM        = 3,
    localparam int IDX_W      = $clog2(DIM)
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  start_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [IDX_W-1:0]      a_row_out,
    output logic [IDX_W-1:0]      a_col_out,
    input  logic [DATA_WIDTH-1:0] a_data_in,
    output logic [IDX_W-1:0]      b_row_out,
    output logic [IDX_W-1:0]      b_col_out,
    input  logic [DATA_WIDTH-1:0] b_data_in,
    output logic                  write_enable_out,
    output logic [IDX_W-1:0]      write_row_out,
    output logic [IDX_W-1:0]      write_col_out,
    output logic [DATA_WIDTH-1:0] write_data_out
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ACC_W  = 2 * DATA_WIDTH + 2;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        WRITEBACK,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         i_q, i_d;
    logic [IDX_W-1:0]         j_q, j_d;
    logic [IDX_W-1:0]         k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_WIDTH-1:0]    res_q [DIM][DIM];
    logic [DATA_WIDTH-1:0]    res_d [DIM][DIM];

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  sum;
    logic [DATA_WIDTH-1:0]    sat_val;

    always_comb begin
        prod = $signed(a_data_in) * $signed(b_data_in);
        sum  = acc_q + {{2{prod[PROD_W-1]}}, prod};
        if (sum > SAT_MAX) begin
            sat_val = SAT_MAX[DATA_WIDTH-1:0];
        end else if (sum < SAT_MIN) begin
            sat_val = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            sat_val = sum[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d          = state_q;
        i_d              = i_q;
        j_d              = j_q;
        k_d              = k_q;
        acc_d            = acc_q;
        res_d            = res_q;
        busy_out         = 1'b0;
        done_out         = 1'b0;
        a_row_out        = '0;
        a_col_out        = '0;
        b_row_out        = '0;
        b_col_out        = '0;
        write_enable_out = 1'b0;
        write_row_out    = '0;
        write_col_out    = '0;
        write_data_out   = '0;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = MAC;
                end
            end

            MAC: begin
                busy_out  = 1'b1;
                a_row_out = i_q;
                a_col_out = k_q;
                b_row_out = k_q;
                b_col_out = j_q;
                if (k_q != LAST) begin
                    acc_d = sum;
                    k_d   = k_q + 1'b1;
                end else begin
                    res_d[i_q][j_q] = sat_val;
                    acc_d = '0;
                    k_d   = '0;
                    if (j_q != LAST) begin
                        j_d = j_q + 1'b1;
                    end else begin
                        j_d = '0;
                        if (i_q != LAST) begin
                            i_d = i_q + 1'b1;
                        end else begin
                            // i/j are reused as the write-back row/column
                            i_d     = '0;
                            state_d = WRITEBACK;
                        end
                    end
                end
            end

            WRITEBACK: begin
                busy_out         = 1'b1;
                write_enable_out = 1'b1;
                write_row_out    = i_q;
                write_col_out    = j_q;
                write_data_out   = res_q[i_q][j_q];
                if (j_q != LAST) begin
                    j_d = j_q + 1'b1;
                end else begin
                    j_d = '0;
                    if (i_q != LAST) begin
                        i_d = i_q + 1'b1;
                    end else begin
                        i_d     = '0;
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                busy_out = 1'b1;
                done_out = 1'b1;
                state_d  = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    // Result buffer contents are meaningless until written, so it has no reset
    always_ff @(posedge clock_in) begin
        res_q <= res_d;
    end

endmodule

// File: tb/tb_tensor_core_matmul_sequencer.sv
// Directed bench for tensor_core_matmul_sequencer: models both register-file read
// ports and checks every cycle of each operation against hand-computed results.
module tb_tensor_core_matmul_sequencer;

    typedef logic signed [7:0] vec9_t [9];

    logic       clock_in = 1'b0;
    logic       reset_in;
    logic       start_in;
    logic       busy_out;
    logic       done_out;
    logic [1:0] a_row_out;
    logic [1:0] a_col_out;
    logic [7:0] a_data_in;
    logic [1:0] b_row_out;
    logic [1:0] b_col_out;
    logic [7:0] b_data_in;
    logic       write_enable_out;
    logic [1:0] write_row_out;
    logic [1:0] write_col_out;
    logic [7:0] write_data_out;

    vec9_t mat_a;
    vec9_t mat_b;
    vec9_t va;
    vec9_t vb;
    vec9_t ve;
    int    vectors     = 0;
    int    miscompares = 0;

    tensor_core_matmul_sequencer #(
        .DATA_WIDTH(8),
        .DIM       (3)
    ) dut (
        .clock_in        (clock_in),
        .reset_in        (reset_in),
        .start_in        (start_in),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .a_row_out       (a_row_out),
        .a_col_out       (a_col_out),
        .a_data_in       (a_data_in),
        .b_row_out       (b_row_out),
        .b_col_out       (b_col_out),
        .b_data_in       (b_data_in),
        .write_enable_out(write_enable_out),
        .write_row_out   (write_row_out),
        .write_col_out   (write_col_out),
        .write_data_out  (write_data_out)
    );

    always #5 clock_in = ~clock_in;

    always_comb begin
        a_data_in = mat_a[{2'b00, a_row_out} * 4'd3 + {2'b00, a_col_out}];
        b_data_in = mat_b[{2'b00, b_row_out} * 4'd3 + {2'b00, b_col_out}];
    end

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic check_output(input string tag, input logic signed [31:0] observed,
                                input logic signed [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input vec9_t a, input vec9_t b);
        mat_a = a;
        mat_b = b;
    endtask

    // Pulse start for one cycle from IDLE; returns in the first MAC cycle (n+1)
    task automatic start_op();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    // Called in cycle n+1; checks cycles n+1..n+38 and returns in cycle n+38
    task automatic expect_run(input vec9_t exp, input bit poke_start);
        for (int c = 1; c <= 38; c++) begin
            check_output("busy", 32'(busy_out), 32'(c <= 37));
            check_output("done", 32'(done_out), 32'(c == 37));
            check_output("write_enable", 32'(write_enable_out), 32'(c >= 28 && c <= 36));
            if (c >= 28 && c <= 36) begin
                check_output("write_row", 32'(write_row_out), 32'((c - 28) / 3));
                check_output("write_col", 32'(write_col_out), 32'((c - 28) % 3));
                check_output("write_data", 32'($signed(write_data_out)), 32'(exp[c - 28]));
            end
            if (poke_start) begin
                start_in = (c == 5 || c == 37);
            end
            if (c < 38) begin
                tick();
            end
        end
    endtask

    task automatic expect_quiet(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            check_output("post_reset_quiet", 32'({busy_out, write_enable_out, done_out}), 32'd0);
            tick();
        end
    endtask

    initial begin
        reset_in = 1'b1;
        start_in = 1'b0;
        va = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        apply_stimulus(va, va);
        tick();
        tick();
        check_output("reset_busy", 32'(busy_out), 32'd0);
        check_output("reset_done", 32'(done_out), 32'd0);
        check_output("reset_write_enable", 32'(write_enable_out), 32'd0);
        check_output("reset_a_index", 32'({a_row_out, a_col_out, b_row_out, b_col_out}), 32'd0);
        check_output("reset_write_bus", 32'({write_row_out, write_col_out, write_data_out}), 32'd0);
        reset_in = 1'b0;
        tick();
        check_output("idle_no_start", 32'(busy_out), 32'd0);

        $display("[TB] identity x sequence");
        va = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        vb = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        ve = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        apply_stimulus(va, vb);
        start_op();
        expect_run(ve, 1'b0);

        $display("[TB] positive saturation");
        va = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
        ve = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
        apply_stimulus(va, va);
        start_op();
        expect_run(ve, 1'b0);

        $display("[TB] negative saturation");
        va = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
        vb = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
        ve = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
        apply_stimulus(va, vb);
        start_op();
        expect_run(ve, 1'b0);

        $display("[TB] small negative products");
        va = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
        vb = '{-3, -3, -3, -3, -3, -3, -3, -3, -3};
        ve = '{-18, -18, -18, -18, -18, -18, -18, -18, -18};
        apply_stimulus(va, vb);
        start_op();
        expect_run(ve, 1'b0);

        $display("[TB] asymmetric operands");
        va = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        vb = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        ve = '{30, 24, 18, 84, 69, 54, 127, 114, 90};
        apply_stimulus(va, vb);
        start_op();
        expect_run(ve, 1'b0);

        $display("[TB] start while busy is ignored");
        start_op();
        expect_run(ve, 1'b1);
        tick();
        check_output("ignored_start_idle", 32'({busy_out, write_enable_out, done_out}), 32'd0);

        $display("[TB] start held high");
        start_in = 1'b1;
        tick();
        expect_run(ve, 1'b0);
        tick();
        start_in = 1'b0;
        expect_run(ve, 1'b0);

        $display("[TB] reset during MAC");
        start_op();
        for (int c = 1; c < 10; c++) begin
            tick();
        end
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        check_output("mac_reset_busy", 32'(busy_out), 32'd0);
        check_output("mac_reset_write_enable", 32'(write_enable_out), 32'd0);
        expect_quiet(45);
        start_op();
        expect_run(ve, 1'b0);

        $display("[TB] reset during write-back");
        va = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        vb = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        ve = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        apply_stimulus(va, vb);
        start_op();
        for (int c = 1; c < 30; c++) begin
            tick();
        end
        check_output("wb_before_reset", 32'(write_enable_out), 32'd1);
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        check_output("wb_reset_busy", 32'(busy_out), 32'd0);
        check_output("wb_reset_write_enable", 32'(write_enable_out), 32'd0);
        expect_quiet(45);
        start_op();
        expect_run(ve, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
